// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB
// with imem/dmem handshakes, write strobes, retire counter and sticky halt/fault.
module rv32i_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    F_NONE    = 2'd0,
    F_ILLEGAL = 2'd1,
    F_TIMEOUT = 2'd2,
    F_SYSTEM  = 2'd3
  } fault_e;

  localparam int              WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam bit              TO_EN  = (MEM_TIMEOUT != 0);

  state_e            state_q, state_nxt;
  fault_e            fault_q, fault_nxt;
  logic [WAIT_W-1:0] wait_q, wait_nxt;
  logic [CNT_W-1:0]  instret_q;

  logic imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, reg_we_c, pc_we_c, pc_sel_c;
  logic legal, is_store, is_branch, timed_out;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  // Expiry is only evaluated when ready is low, so a last-cycle ready still wins.
  assign timed_out = TO_EN && (wait_q == TO_VAL);

  always_comb begin
    state_nxt  = state_q;
    fault_nxt  = fault_q;
    wait_nxt   = '0;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    reg_we_c   = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_we_c   = 1'b1;
          state_nxt = S_DECODE;
        end else if (timed_out) begin
          state_nxt = S_HALT;
          fault_nxt = F_TIMEOUT;
        end else begin
          wait_nxt = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_HALT;
          fault_nxt = F_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEM;
          OP_FENCE: begin
            pc_we_c   = 1'b1;
            state_nxt = S_FETCH;
          end
          OP_SYSTEM: begin
            state_nxt = S_HALT;
            fault_nxt = F_SYSTEM;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we_c   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timed_out) begin
          state_nxt = S_HALT;
          fault_nxt = F_TIMEOUT;
        end else begin
          wait_nxt = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        pc_we_c   = 1'b1;
        reg_we_c  = !(is_branch || is_store) && (rd != 5'd0);
        pc_sel_c  = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                    (is_branch && branch_taken);
        state_nxt = S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      fault_q   <= F_NONE;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_nxt;
      fault_q <= fault_nxt;
      wait_q  <= wait_nxt;
      if (pc_we_c) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Everything is gated by reset so an in-flight request drops immediately.
  assign imem_req = reset_n & imem_req_c;
  assign ir_we    = reset_n & ir_we_c;
  assign dmem_req = reset_n & dmem_req_c;
  assign dmem_we  = reset_n & dmem_we_c;
  assign reg_we   = reset_n & reg_we_c;
  assign pc_we    = reset_n & pc_we_c;
  assign pc_sel   = reset_n & pc_sel_c;
  assign halted   = reset_n & (state_q == S_HALT);
  assign fault    = reset_n ? fault_q : 2'd0;
  assign instret  = reset_n ? instret_q : '0;
  assign state    = reset_n ? state_q : 3'd0;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Directed bench for rv32i_ctrl_fsm with MEM_TIMEOUT=4; expected values hand-derived.
module tb_rv32i_ctrl_fsm;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        branch_taken, imem_ready, dmem_ready;
  logic        imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, halted;
  logic [1:0]  fault;
  logic [31:0] instret;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  rv32i_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .rd(rd),
    .branch_taken(branch_taken), .imem_req(imem_req), .imem_ready(imem_ready),
    .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted),
    .fault(fault), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are then changed at +1 and outputs checked at +3
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  // zero-wait fetch of the given opcode; leaves the FSM in DECODE
  task automatic fetch(input logic [6:0] op, input logic [4:0] r);
    opcode = op; rd = r; imem_ready = 1'b1;
    settle();
    chk("fetch_ir_we", ir_we, 1);
    cyc();
    imem_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; opcode = OP_OP; rd = 5'd5; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    cyc(); cyc();
    settle();
    chk("rst_state", state, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_instret", instret, 0);
    chk("rst_fault", fault, 0);
    reset_n = 1'b1;
    settle();
    chk("fetch_req", imem_req, 1);

    // OP rd=5: states 0,1,2,4
    fetch(OP_OP, 5'd5);
    settle(); chk("op_decode", state, 1);
    cyc(); settle(); chk("op_exec", state, 2);
    cyc(); settle();
    chk("op_wb_state", state, 4);
    chk("op_wb_reg_we", reg_we, 1);
    chk("op_wb_pc_we", pc_we, 1);
    chk("op_wb_pc_sel", pc_sel, 0);
    chk("op_instret_before", instret, 0);
    cyc(); settle();
    chk("op_back_fetch", state, 0);
    chk("op_instret_after", instret, 1);

    // branch taken then not taken
    fetch(OP_BRANCH, 5'd7);
    cyc(); cyc();
    branch_taken = 1'b1; settle();
    chk("br1_reg_we", reg_we, 0);
    chk("br1_pc_sel", pc_sel, 1);
    chk("br1_pc_we", pc_we, 1);
    cyc();
    fetch(OP_BRANCH, 5'd7);
    cyc(); cyc();
    branch_taken = 1'b0; settle();
    chk("br0_reg_we", reg_we, 0);
    chk("br0_pc_sel", pc_sel, 0);
    cyc(); settle();
    chk("br_instret", instret, 3);

    // load with dmem_ready delayed 3 cycles
    fetch(OP_LOAD, 5'd5);
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      settle();
      chk("ld_mem_state", state, 3);
      chk("ld_dmem_req", dmem_req, 1);
      chk("ld_dmem_we", dmem_we, 0);
      cyc();
    end
    dmem_ready = 1'b0; settle();
    chk("ld_wb_state", state, 4);
    chk("ld_wb_reg_we", reg_we, 1);
    cyc(); settle();
    chk("ld_instret", instret, 4);

    // zero-wait store retires from MEM
    fetch(OP_STORE, 5'd3);
    cyc(); cyc();
    dmem_ready = 1'b1; settle();
    chk("st_dmem_we", dmem_we, 1);
    chk("st_pc_we", pc_we, 1);
    chk("st_reg_we", reg_we, 0);
    cyc(); dmem_ready = 1'b0; settle();
    chk("st_fetch", state, 0);
    chk("st_instret", instret, 5);

    // fence retires from EXEC
    fetch(OP_FENCE, 5'd0);
    cyc(); settle();
    chk("fence_pc_we", pc_we, 1);
    chk("fence_pc_sel", pc_sel, 0);
    cyc(); settle();
    chk("fence_fetch", state, 0);
    chk("fence_instret", instret, 6);

    // ready arrives in the last allowed cycle, then an illegal opcode
    opcode = 7'b1111111;
    for (int i = 0; i < 4; i++) begin
      settle(); chk("late_req", imem_req, 1);
      cyc();
    end
    imem_ready = 1'b1; settle();
    chk("late_ir_we", ir_we, 1);
    cyc(); imem_ready = 1'b0; settle();
    chk("late_decode", state, 1);
    cyc(); settle();
    chk("ill_state", state, 5);
    chk("ill_fault", fault, 1);
    chk("ill_halted", halted, 1);
    chk("ill_instret", instret, 6);
    cyc(); settle();
    chk("ill_sticky", halted, 1);
    reset_n = 1'b0; settle();
    chk("rst_halted_comb", halted, 0);
    do_reset();

    // SYSTEM halts from EXEC
    fetch(OP_SYSTEM, 5'd0);
    cyc(); cyc(); settle();
    chk("sys_fault", fault, 3);
    chk("sys_halted", halted, 1);
    chk("sys_pc_we", pc_we, 0);
    chk("sys_instret", instret, 0);
    do_reset();

    // fetch timeout: 5 request cycles then HALT
    for (int i = 0; i < 5; i++) begin
      settle(); chk("to_req", imem_req, 1);
      cyc();
    end
    settle();
    chk("to_state", state, 5);
    chk("to_fault", fault, 2);
    chk("to_halted", halted, 1);
    chk("to_imem_req", imem_req, 0);
    do_reset();

    // reset during a pending store
    fetch(OP_OP, 5'd1);
    cyc(); cyc(); cyc();
    fetch(OP_STORE, 5'd0);
    cyc(); cyc(); settle();
    chk("rst_st_pre_req", dmem_req, 1);
    chk("rst_st_pre_instret", instret, 1);
    reset_n = 1'b0; settle();
    chk("rst_st_drop", dmem_req, 0);
    cyc(); cyc();
    reset_n = 1'b1; settle();
    chk("rst_st_state", state, 0);
    chk("rst_st_instret", instret, 0);
    chk("rst_st_fault", fault, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
